sbox_server: RTL and testbench

Shared, registered AES S-box responder. It serves byte-substitution requests from the key scheduler and from the round datapath. Each granted request gets its forward or inverse S-box result exactly one cycle later. The key-scheduler port has fixed priority and is never stalled. The datapath port is granted only when the key scheduler is idle, and it sees its grant in the same cycle it asks.

---
 rtl/sbox_server.sv | 112 +++++++++++
 tb/tb_sbox_server.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_server.sv
// rtl/sbox_server.sv - shared registered AES S-box responder for key scheduler and datapath
module sbox_server (
    input  logic       clk,
    input  logic       reset,
    input  logic       ks_access_i,
    input  logic [7:0] ks_data_i,
    input  logic       ks_decrypt_i,
    output logic [7:0] ks_data_o,
    output logic       ks_valid_o,
    input  logic       dp_access_i,
    input  logic [7:0] dp_data_i,
    input  logic       dp_decrypt_i,
    output logic       dp_grant_o,
    output logic [7:0] dp_data_o,
    output logic       dp_valid_o
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_KS   = 2'd1,
        OWN_DP   = 2'd2
    } owner_e;

    owner_e     owner_q, owner_d;
    logic [7:0] ks_data_q, ks_data_d;
    logic [7:0] dp_data_q, dp_data_d;
    logic [7:0] op_byte;
    logic       op_decrypt;
    logic [7:0] engine_result;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; naturally maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] a);
        return a ^ rotl(a, 1) ^ rotl(a, 2) ^ rotl(a, 3) ^ rotl(a, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] a);
        return rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
    endfunction

    // Arbitration: key scheduler always wins, datapath only gets idle cycles
    assign dp_grant_o = dp_access_i & ~ks_access_i;

    // Operand mux and the single lookup engine
    always_comb begin
        op_byte    = ks_access_i ? ks_data_i    : dp_data_i;
        op_decrypt = ks_access_i ? ks_decrypt_i : dp_decrypt_i;
        if (op_decrypt) engine_result = gf_inv(affine_inv(op_byte));
        else            engine_result = affine_fwd(gf_inv(op_byte));
    end

    // Next owner and per-port result capture; the non-owner port holds its value
    always_comb begin
        owner_d   = OWN_IDLE;
        ks_data_d = ks_data_q;
        dp_data_d = dp_data_q;
        if (ks_access_i) begin
            owner_d   = OWN_KS;
            ks_data_d = engine_result;
        end else if (dp_access_i) begin
            owner_d   = OWN_DP;
            dp_data_d = engine_result;
        end
    end

    // Owner flag and result registers; reset discards any in-flight result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q   <= OWN_IDLE;
            ks_data_q <= 8'h00;
            dp_data_q <= 8'h00;
        end else begin
            owner_q   <= owner_d;
            ks_data_q <= ks_data_d;
            dp_data_q <= dp_data_d;
        end
    end

    assign ks_data_o  = ks_data_q;
    assign dp_data_o  = dp_data_q;
    assign ks_valid_o = (owner_q == OWN_KS);
    assign dp_valid_o = (owner_q == OWN_DP);

endmodule

// File: tb/tb_sbox_server.sv
// tb/tb_sbox_server.sv - self-checking bench for sbox_server
module tb_sbox_server;

    logic       clk = 1'b0;
    logic       reset;
    logic       ks_access_i, ks_decrypt_i;
    logic [7:0] ks_data_i;
    logic [7:0] ks_data_o;
    logic       ks_valid_o;
    logic       dp_access_i, dp_decrypt_i;
    logic [7:0] dp_data_i;
    logic       dp_grant_o;
    logic [7:0] dp_data_o;
    logic       dp_valid_o;

    int errors = 0;
    int checks = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];
    logic [7:0] sweep_res [256];

    logic [7:0] exp_ks_data, exp_dp_data;
    logic       exp_ks_valid, exp_dp_valid;

    sbox_server dut (
        .clk          (clk),
        .reset        (reset),
        .ks_access_i  (ks_access_i),
        .ks_data_i    (ks_data_i),
        .ks_decrypt_i (ks_decrypt_i),
        .ks_data_o    (ks_data_o),
        .ks_valid_o   (ks_valid_o),
        .dp_access_i  (dp_access_i),
        .dp_data_i    (dp_data_i),
        .dp_decrypt_i (dp_decrypt_i),
        .dp_grant_o   (dp_grant_o),
        .dp_data_o    (dp_data_o),
        .dp_valid_o   (dp_valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        int acc = 0;
        int aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = aa << 1;
            if (aa >= 256) aa = aa ^ 'h11B;
        end
        return acc[7:0];
    endfunction

    // Tables from first principles: inverse by search, affine bitwise
    task automatic build_tables();
        logic [7:0] c;
        logic [7:0] a, b;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            a = 8'h00;
            for (int y = 1; y < 256; y++)
                if (mul(x[7:0], y[7:0]) == 8'h01) a = y[7:0];
            for (int i = 0; i < 8; i++)
                b[i] = a[i] ^ a[(i+4)%8] ^ a[(i+5)%8] ^ a[(i+6)%8] ^ a[(i+7)%8] ^ c[i];
            fwd_tab[x] = b;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = x[7:0];
    endtask

    // Behavioural model: accepted request produces the table value one edge later
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_ks_data = 8'h00; exp_dp_data = 8'h00;
            exp_ks_valid = 1'b0; exp_dp_valid = 1'b0;
        end else begin
            exp_ks_valid = ks_access_i;
            exp_dp_valid = dp_access_i & ~ks_access_i;
            if (ks_access_i)
                exp_ks_data = ks_decrypt_i ? inv_tab[ks_data_i] : fwd_tab[ks_data_i];
            else if (dp_access_i)
                exp_dp_data = dp_decrypt_i ? inv_tab[dp_data_i] : fwd_tab[dp_data_i];
        end
    end

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        check("ks_data_o", ks_data_o, exp_ks_data);
        check("dp_data_o", dp_data_o, exp_dp_data);
        check("ks_valid_o", {7'd0, ks_valid_o}, {7'd0, exp_ks_valid});
        check("dp_valid_o", {7'd0, dp_valid_o}, {7'd0, exp_dp_valid});
        check("dp_grant_o", {7'd0, dp_grant_o}, {7'd0, dp_access_i & ~ks_access_i});
    end

    task automatic cyc(input logic ka, input logic [7:0] kd, input logic kdec,
                       input logic da, input logic [7:0] dd, input logic ddec);
        ks_access_i = ka; ks_data_i = kd; ks_decrypt_i = kdec;
        dp_access_i = da; dp_data_i = dd; dp_decrypt_i = ddec;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] kin [4];
        logic [7:0] kout [4];
        logic [7:0] bin [5];
        logic [7:0] bout [5];
        logic [7:0] din [3];
        logic [7:0] dout [3];
        kin  = '{8'h00, 8'h01, 8'h53, 8'hFF};
        kout = '{8'h63, 8'h7C, 8'hED, 8'h16};
        din  = '{8'h63, 8'hED, 8'h00};
        dout = '{8'h00, 8'h53, 8'h52};
        bin  = '{8'h0C, 8'h4F, 8'h3C, 8'h09, 8'h53};
        bout = '{8'hFE, 8'h84, 8'hEB, 8'h01, 8'hED};

        build_tables();
        check("tab_fwd_00", fwd_tab[8'h00], 8'h63);
        check("tab_fwd_53", fwd_tab[8'h53], 8'hED);
        check("tab_fwd_ff", fwd_tab[8'hFF], 8'h16);
        check("tab_fwd_0c", fwd_tab[8'h0C], 8'hFE);
        check("tab_inv_00", inv_tab[8'h00], 8'h52);

        reset = 1'b0;
        ks_access_i = 0; ks_data_i = 0; ks_decrypt_i = 0;
        dp_access_i = 0; dp_data_i = 0; dp_decrypt_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ks_data", ks_data_o, 8'h00);
        check("rst_dp_data", dp_data_o, 8'h00);
        check("rst_valids", {6'd0, ks_valid_o, dp_valid_o}, 8'h00);
        check("rst_grant", {7'd0, dp_grant_o}, 8'h00);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);

        // ks forward stream
        for (int i = 0; i < 4; i++) begin
            cyc(1, kin[i], 0, 0, 0, 0);
            check("ks_fwd", ks_data_o, kout[i]);
            check("ks_fwd_valid", {7'd0, ks_valid_o}, 8'h01);
        end
        cyc(0, 0, 0, 0, 0, 0);
        check("ks_hold", ks_data_o, 8'h16);
        check("ks_idle_valid", {7'd0, ks_valid_o}, 8'h00);

        // dp inverse stream
        for (int i = 0; i < 3; i++) begin
            ks_access_i = 0; dp_access_i = 1; dp_data_i = din[i]; dp_decrypt_i = 1;
            #1 check("dp_grant", {7'd0, dp_grant_o}, 8'h01);
            @(posedge clk); #1;
            check("dp_inv", dp_data_o, dout[i]);
            check("dp_ks_untouched", ks_data_o, 8'h16);
        end

        // collision: ks wins, dp held one extra cycle
        cyc(1, 8'h53, 0, 1, 8'h01, 0);
        check("coll_ks", ks_data_o, 8'hED);
        check("coll_dp_hold", dp_data_o, 8'h52);
        check("coll_dp_novalid", {7'd0, dp_valid_o}, 8'h00);
        cyc(0, 0, 0, 1, 8'h01, 0);
        check("coll_dp", dp_data_o, 8'h7C);

        // exhaustive forward sweep, alternating ports, then inverse round-trip
        for (int x = 0; x < 256; x++) begin
            if (x % 2 == 0) begin
                cyc(1, x[7:0], 0, 0, 0, 0); sweep_res[x] = ks_data_o;
            end else begin
                cyc(0, 0, 0, 1, x[7:0], 0); sweep_res[x] = dp_data_o;
            end
        end
        for (int x = 0; x < 256; x++) begin
            if (x % 2 == 1) begin
                cyc(1, sweep_res[x], 1, 0, 0, 0); check("roundtrip", ks_data_o, x[7:0]);
            end else begin
                cyc(0, 0, 0, 1, sweep_res[x], 1); check("roundtrip", dp_data_o, x[7:0]);
            end
        end
        cyc(0, 0, 0, 0, 0, 0);

        // reset while a ks request is in flight
        ks_access_i = 1; ks_data_i = 8'h53; ks_decrypt_i = 0;
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_ks_data", ks_data_o, 8'h00);
        check("midrst_ks_valid", {7'd0, ks_valid_o}, 8'h00);
        ks_access_i = 0;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        cyc(1, 8'h53, 0, 0, 0, 0);
        check("postrst_ks", ks_data_o, 8'hED);

        // 5-cycle key-scheduler burst starving a waiting datapath request
        for (int i = 0; i < 5; i++) begin
            cyc(1, bin[i], 0, 1, 8'hFF, 0);
            check("burst_ks", ks_data_o, bout[i]);
            check("burst_dp_novalid", {7'd0, dp_valid_o}, 8'h00);
        end
        cyc(0, 0, 0, 1, 8'hFF, 0);
        check("burst_dp_served", dp_data_o, 8'h16);
        check("burst_dp_valid", {7'd0, dp_valid_o}, 8'h01);
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
